// File: rtl/fetch_pkg.sv
// Shared fetch types, constants and helpers.
// Imported by the fetch realigner and its halfword queue.
package fetch_pkg;

    localparam int QDEPTH_HW = 4;

    localparam logic [1:0] RVC_Q0  = 2'b00;
    localparam logic [1:0] RVC_Q1  = 2'b01;
    localparam logic [1:0] RVC_Q2  = 2'b10;
    localparam logic [1:0] OP_FULL = 2'b11;

    typedef enum logic [1:0] {
        F_IDLE,
        F_BUSY,
        F_DROP
    } fetch_state_e;

    function automatic logic is_comp(input logic [15:0] hw);
        return hw[1:0] != OP_FULL;
    endfunction

endpackage

// File: rtl/fetch_align_unit_queue.sv
// Halfword FIFO, variable push/pop of 0..2 entries.
// Entry 0 is always the head; flush empties it.
module fetch_hw_queue
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [1:0]  push,
    input  logic [15:0] push_lo,
    input  logic [15:0] push_hi,
    input  logic [1:0]  pop,
    output logic [2:0]  count,
    output logic [15:0] head0,
    output logic [15:0] head1
);

    logic [15:0] q   [QDEPTH_HW];
    logic [15:0] q_n [QDEPTH_HW];
    logic [2:0]  count_n;

    assign head0 = q[0];
    assign head1 = q[1];

    // Shift out popped entries, then append pushed ones behind survivors.
    always_comb begin
        count_n = count + 3'(push) - 3'(pop);
        for (int i = 0; i < QDEPTH_HW; i++) begin
            int src;
            src = i + int'(pop);
            q_n[i] = '0;
            if (src < int'(count))
                q_n[i] = q[2'(src)];
            else if (src == int'(count) && push != 2'd0)
                q_n[i] = push_lo;
            else if (src == int'(count) + 1 && push == 2'd2)
                q_n[i] = push_hi;
        end
        if (flush)
            count_n = '0;
    end

    // Queue storage and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < QDEPTH_HW; i++)
                q[i] <= '0;
        end else begin
            if (!flush)
                assert (int'(count) + int'(push) - int'(pop) <= QDEPTH_HW);
            count <= count_n;
            for (int i = 0; i < QDEPTH_HW; i++)
                q[i] <= q_n[i];
        end
    end

endmodule

// File: rtl/fetch_align_unit.sv
// Fetch realigner: word fetches in, aligned
// 16/32-bit instructions with PC out.
module fetch_align_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_is_comp_o
);

    fetch_state_e state, state_n;
    logic [31:0]  fetch_pc, head_pc;
    logic         skip_lo, req_en;
    logic [2:0]   count;
    logic [15:0]  hw0, hw1, push_lo;
    logic [1:0]   push, pop;
    logic         req_fire, rsp_push, hs;
    logic         hw0_comp, valid;

    assign hw0_comp = is_comp(hw0);
    assign valid = (count >= 3'd1 && hw0_comp)
                || (count >= 3'd2 && !hw0_comp);

    assign inst_valid_o   = valid;
    assign inst_o         = !valid   ? 32'h0
                          : hw0_comp ? {16'h0, hw0}
                          :            {hw1, hw0};
    assign inst_pc_o      = head_pc;
    assign inst_is_comp_o = valid && hw0_comp;

    assign imem_req_valid_o = req_en && state == F_IDLE
                           && count <= 3'd2 && !redirect_i;
    assign imem_req_addr_o  = fetch_pc;

    assign req_fire = imem_req_valid_o && imem_req_ready_i;
    assign hs       = valid && inst_ready_i;
    assign pop      = !hs ? 2'd0 : hw0_comp ? 2'd1 : 2'd2;
    assign push     = !rsp_push ? 2'd0 : skip_lo ? 2'd1 : 2'd2;
    assign push_lo  = skip_lo ? imem_rsp_data_i[31:16]
                              : imem_rsp_data_i[15:0];

    // Request tracking: idle, waiting for data, or waiting to discard.
    always_comb begin
        state_n  = state;
        rsp_push = 1'b0;
        unique case (state)
            F_IDLE: begin
                if (req_fire)
                    state_n = F_BUSY;
            end
            F_BUSY, F_DROP: begin
                if (redirect_i) begin
                    state_n = imem_rsp_valid_i ? F_IDLE : F_DROP;
                end else if (imem_rsp_valid_i) begin
                    state_n  = F_IDLE;
                    rsp_push = (state == F_BUSY);
                end
            end
            default: state_n = F_IDLE;
        endcase
    end

    // State, fetch PC and head PC; redirect overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= F_IDLE;
            req_en   <= 1'b0;
            fetch_pc <= RESET_PC & ~32'h3;
            head_pc  <= RESET_PC & ~32'h1;
            skip_lo  <= RESET_PC[1];
        end else begin
            req_en <= 1'b1;
            state  <= state_n;
            if (redirect_i) begin
                fetch_pc <= redirect_pc_i & ~32'h3;
                head_pc  <= redirect_pc_i & ~32'h1;
                skip_lo  <= redirect_pc_i[1];
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (rsp_push)
                    skip_lo <= 1'b0;
                if (hs)
                    head_pc <= head_pc + (hw0_comp ? 32'd2 : 32'd4);
            end
        end
    end

    fetch_hw_queue u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (redirect_i),
        .push    (push),
        .push_lo (push_lo),
        .push_hi (imem_rsp_data_i[31:16]),
        .pop     (pop),
        .count   (count),
        .head0   (hw0),
        .head1   (hw1)
    );

endmodule

// File: tb/tb_fetch_align_unit.sv
// Bench for fetch_align_unit: memory model plus
// instruction-stream reference, random and directed.
module tb_fetch_align_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i = 1'b0;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_is_comp_o;

    fetch_align_unit #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .inst_is_comp_o   (inst_is_comp_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory contents: directed words, otherwise a fixed hash of the address.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w, x;
        w = a & ~32'h3;
        if (mem.exists(w))
            return mem[w];
        x = w * 32'h9E37_79B1;
        x = x ^ (x >> 13);
        x = x * 32'h85EB_CA6B;
        x = x ^ (x >> 16);
        return x;
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = word_at(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    bit          pend = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] last_req = '0;
    int          dmin = 1, dmax = 1, rdy_pct = 100;
    logic [31:0] req_q[$];

    // Memory responder: one request at a time, answers dmin..dmax later.
    initial begin
        forever begin
            @(posedge clk); #1;
            imem_rsp_valid_i = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_rsp_valid_i = 1'b1;
                    imem_rsp_data_i  = word_at(pend_addr);
                    pend = 0;
                end
            end
            imem_req_ready_i = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            if (rst_n && imem_req_valid_o && imem_req_ready_i) begin
                check("one_outstanding", {31'b0, pend}, 32'd0);
                check("addr_align", {30'b0, imem_req_addr_o[1:0]}, 32'd0);
                pend      = 1;
                pend_addr = imem_req_addr_o;
                pend_cnt  = $urandom_range(dmax, dmin);
                last_req  = imem_req_addr_o;
                req_q.push_back(imem_req_addr_o);
            end
        end
    end

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        comp;
    } hs_t;

    hs_t         hs_q[$];
    int          hs_cnt = 0;
    logic [31:0] mpc = RST_PC;
    logic        pv = 0, pr = 0, prd = 0, pcomp = 0;
    logic [31:0] pinst = '0, ppc = '0;

    // Reference: walk memory from the model PC, check every handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mpc = RST_PC;
                pv  = 0;
                continue;
            end
            if (pv && !pr && !prd) begin
                check("hold_valid", {31'b0, inst_valid_o}, 32'd1);
                check("hold_inst", inst_o, pinst);
                check("hold_pc", inst_pc_o, ppc);
                check("hold_comp", {31'b0, inst_is_comp_o}, {31'b0, pcomp});
            end
            if (redirect_i)
                check("no_req_in_redirect", {31'b0, imem_req_valid_o}, 32'd0);
            if (inst_valid_o && inst_ready_i) begin
                logic [15:0] h0;
                logic        c;
                logic [31:0] e;
                h0 = hw_at(mpc);
                c  = (h0[1:0] != 2'b11);
                e  = c ? {16'h0, h0} : {hw_at(mpc + 32'd2), h0};
                check("inst", inst_o, e);
                check("inst_pc", inst_pc_o, mpc);
                check("inst_comp", {31'b0, inst_is_comp_o}, {31'b0, c});
                hs_q.push_back('{inst_o, inst_pc_o, inst_is_comp_o});
                hs_cnt++;
                mpc = mpc + (c ? 32'd2 : 32'd4);
            end
            if (redirect_i)
                mpc = redirect_pc_i & ~32'h1;
            pv    = inst_valid_o;
            pr    = inst_ready_i;
            prd   = redirect_i;
            pinst = inst_o;
            ppc   = inst_pc_o;
            pcomp = inst_is_comp_o;
        end
    end

    task automatic wait_hs(input int n, input int maxc);
        int start, c;
        start = hs_cnt;
        c = 0;
        while (hs_cnt - start < n && c < maxc) begin
            @(posedge clk); #2;
            c++;
        end
        check("wait_hs", {31'b0, (hs_cnt - start >= n)}, 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(posedge clk); #2;
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        @(posedge clk); #2;
        redirect_i = 1'b0;
        hs_q.delete();
        req_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, {31'b0, imem_req_valid_o}, 32'd0);
        check({tag, "_inst_valid"}, {31'b0, inst_valid_o}, 32'd0);
        check({tag, "_inst"}, inst_o, 32'd0);
        check({tag, "_pc"}, inst_pc_o, RST_PC);
        check({tag, "_comp"}, {31'b0, inst_is_comp_o}, 32'd0);
    endtask

    initial begin
        int c, h0;
        mem[32'h0000_0100] = 32'h0001_4501;
        mem[32'h0000_0000] = 32'h0013_4505;
        mem[32'h0000_0004] = 32'hAAAA_0000;
        mem[32'h0000_0200] = 32'h1234_5679;

        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        inst_ready_i = 1'b1;

        wait_hs(2, 50);
        check("t1_req_addr", req_q.size() > 0 ? req_q[0] : 32'hFFFF_FFFF,
              32'h0000_0100);
        check("t1_inst0", hs_q[0].inst, 32'h0000_4501);
        check("t1_pc0", hs_q[0].pc, 32'h0000_0100);
        check("t1_comp0", {31'b0, hs_q[0].comp}, 32'd1);
        check("t1_inst1", hs_q[1].inst, 32'h0000_0001);
        check("t1_pc1", hs_q[1].pc, 32'h0000_0102);
        check("t1_comp1", {31'b0, hs_q[1].comp}, 32'd1);

        do_redirect(32'h0000_0000);
        wait_hs(2, 50);
        check("t2_inst0", hs_q[0].inst, 32'h0000_4505);
        check("t2_pc0", hs_q[0].pc, 32'h0000_0000);
        check("t2_inst1", hs_q[1].inst, 32'h0000_0013);
        check("t2_pc1", hs_q[1].pc, 32'h0000_0002);
        check("t2_comp1", {31'b0, hs_q[1].comp}, 32'd0);

        do_redirect(32'h0000_0202);
        wait_hs(1, 50);
        check("t3_req_addr", req_q.size() > 0 ? req_q[0] : 32'hFFFF_FFFF,
              32'h0000_0200);
        check("t3_pc", hs_q[0].pc, 32'h0000_0202);
        check("t3_inst", hs_q[0].inst, 32'h0000_1234);

        dmin = 4;
        dmax = 4;
        c = 0;
        while (!pend && c < 50) begin
            @(posedge clk); #2;
            c++;
        end
        check("t4_pending", {31'b0, pend}, 32'd1);
        do_redirect(32'h0000_0400);
        wait_hs(3, 100);
        check("t4_req_addr", req_q.size() > 0 ? req_q[0] : 32'hFFFF_FFFF,
              32'h0000_0400);
        check("t4_pc", hs_q[0].pc, 32'h0000_0400);
        dmin = 1;
        dmax = 1;

        wait_hs(2, 50);
        inst_ready_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("t5_req_stalled", {31'b0, imem_req_valid_o}, 32'd0);
        check("t5_valid", {31'b0, inst_valid_o}, 32'd1);
        check("t5_ahead", {31'b0, (last_req + 32'd4 - mpc <= 32'd8)}, 32'd1);
        inst_ready_i = 1'b1;
        wait_hs(8, 100);

        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #2;
        hs_q.delete();
        rst_n = 1'b1;
        wait_hs(2, 50);
        check("t6_pc0", hs_q[0].pc, 32'h0000_0100);
        check("t6_inst0", hs_q[0].inst, 32'h0000_4501);

        rdy_pct = 70;
        dmin = 1;
        dmax = 3;
        h0 = hs_cnt;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            inst_ready_i = ($urandom_range(3) != 0);
            if ($urandom_range(63) == 0) begin
                redirect_i    = 1'b1;
                redirect_pc_i = $urandom & 32'h0000_0FFF;
            end else begin
                redirect_i = 1'b0;
            end
        end
        @(posedge clk); #2;
        redirect_i = 1'b0;
        check("rand_progress", {31'b0, (hs_cnt - h0 > 300)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
